// File: rtl/ip_dest_classifier.sv
// Two-stage valid/ready classifier for destination IPv4 addresses against a table of configured subnets.
// Statistics counters are built only when IP_CLASSIFIER_STATS_EN is defined.
module ip_dest_classifier #(
  parameter int unsigned NUM_SUBNETS = 4,
  parameter int unsigned IDX_WIDTH   = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               s_dest_ip,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [32*NUM_SUBNETS-1:0] cfg_gateway_ip,
  input  logic [32*NUM_SUBNETS-1:0] cfg_subnet_mask,
  input  logic [NUM_SUBNETS-1:0]    cfg_subnet_en,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [31:0]               m_dest_ip,
  output logic                      m_is_broadcast,
  output logic                      m_is_multicast,
  output logic                      m_is_subnet_broadcast,
  output logic                      m_is_local,
  output logic [IDX_WIDTH-1:0]      m_subnet_index,
  input  logic                      stat_clear,
  output logic [CNT_WIDTH-1:0]      stat_bcast_cnt,
  output logic [CNT_WIDTH-1:0]      stat_local_cnt,
  output logic [CNT_WIDTH-1:0]      stat_remote_cnt
);

  logic                   v1_q, v1_d, v2_q, v2_d;
  logic                   ready2, load1, load2;
  logic [31:0]            dest1_q, dest2_q;
  logic [NUM_SUBNETS-1:0] hit1_q, hit_d, sb1_q, sb_d;
  logic                   bc_q, bc_d, mc_q, mc_d, sbc_q, sbc_d, loc_q, loc_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   found;

  // S1 may load whenever S2 is empty or draining, which keeps full throughput.
  assign ready2  = !v2_q || m_ready;
  assign s_ready = !v1_q || ready2;
  assign load1   = s_valid && s_ready;
  assign load2   = v1_q && ready2;

  always_comb begin
    v1_d = s_ready ? s_valid : v1_q;
    v2_d = ready2  ? v1_q    : v2_q;
  end

  always_comb begin
    hit_d = '0;
    sb_d  = '0;
    for (int unsigned i = 0; i < NUM_SUBNETS; i++) begin
      hit_d[i] = cfg_subnet_en[i] &&
                 (((s_dest_ip ^ cfg_gateway_ip[32*i +: 32]) & cfg_subnet_mask[32*i +: 32]) == '0);
      sb_d[i]  = ((s_dest_ip | cfg_subnet_mask[32*i +: 32]) == '1) &&
                 (cfg_subnet_mask[32*i +: 32] != '1);
    end
  end

  always_comb begin
    found = 1'b0;
    idx_d = '0;
    sbc_d = 1'b0;
    loc_d = |hit1_q;
    bc_d  = (dest1_q == '1);
    mc_d  = (dest1_q[31:28] == 4'hE);
    for (int unsigned i = 0; i < NUM_SUBNETS; i++) begin
      if (hit1_q[i] && !found) begin
        found = 1'b1;
        idx_d = IDX_WIDTH'(i);
        sbc_d = sb1_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      dest1_q <= '0;
      hit1_q  <= '0;
      sb1_q   <= '0;
      dest2_q <= '0;
      bc_q    <= 1'b0;
      mc_q    <= 1'b0;
      sbc_q   <= 1'b0;
      loc_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (load1) begin
        dest1_q <= s_dest_ip;
        hit1_q  <= hit_d;
        sb1_q   <= sb_d;
      end
      if (load2) begin
        dest2_q <= dest1_q;
        bc_q    <= bc_d;
        mc_q    <= mc_d;
        sbc_q   <= sbc_d;
        loc_q   <= loc_d;
        idx_q   <= idx_d;
      end
    end
  end

  assign m_valid               = v2_q;
  assign m_dest_ip             = dest2_q;
  assign m_is_broadcast        = bc_q;
  assign m_is_multicast        = mc_q;
  assign m_is_subnet_broadcast = sbc_q;
  assign m_is_local            = loc_q;
  assign m_subnet_index        = idx_q;

`ifdef IP_CLASSIFIER_STATS_EN
  logic                 out_hs;
  logic [CNT_WIDTH-1:0] bcnt_q, lcnt_q, rcnt_q;

  assign out_hs = v2_q && m_ready;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= '0;
      lcnt_q <= '0;
      rcnt_q <= '0;
    end else if (stat_clear) begin
      bcnt_q <= '0;
      lcnt_q <= '0;
      rcnt_q <= '0;
    end else if (out_hs) begin
      if ((bc_q || sbc_q) && (bcnt_q != '1)) bcnt_q <= bcnt_q + CNT_WIDTH'(1);
      if (loc_q && (lcnt_q != '1))           lcnt_q <= lcnt_q + CNT_WIDTH'(1);
      if (!loc_q && !bc_q && !mc_q && (rcnt_q != '1)) rcnt_q <= rcnt_q + CNT_WIDTH'(1);
    end
  end

  assign stat_bcast_cnt  = bcnt_q;
  assign stat_local_cnt  = lcnt_q;
  assign stat_remote_cnt = rcnt_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign stat_bcast_cnt    = '0;
  assign stat_local_cnt    = '0;
  assign stat_remote_cnt   = '0;
`endif

endmodule

// File: tb/tb_ip_dest_classifier.sv
// Bench for ip_dest_classifier: directed table, hand-written pipeline corner sequences, then random traffic
// checked by a scoreboard fed from a behavioural subnet-matching model.
module tb_ip_dest_classifier;
  localparam int NS = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     s_dest_ip = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [32*NS-1:0] cfg_gw, cfg_mk;
  logic [NS-1:0]   en_v = '0;
  logic            m_valid, m_ready = 1'b0;
  logic [31:0]     m_dest_ip;
  logic            m_is_broadcast, m_is_multicast, m_is_subnet_broadcast, m_is_local;
  logic [1:0]      m_subnet_index;
  logic            stat_clear = 1'b0;
  logic [CW-1:0]   stat_bcast_cnt, stat_local_cnt, stat_remote_cnt;

  logic [31:0] gw[NS];
  logic [31:0] mk[NS];

  always #5 clk = ~clk;

  always_comb begin
    cfg_gw = '0;
    cfg_mk = '0;
    for (int i = 0; i < NS; i++) begin
      cfg_gw[32*i +: 32] = gw[i];
      cfg_mk[32*i +: 32] = mk[i];
    end
  end

  ip_dest_classifier #(.NUM_SUBNETS(NS), .IDX_WIDTH(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_dest_ip(s_dest_ip), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_gateway_ip(cfg_gw), .cfg_subnet_mask(cfg_mk), .cfg_subnet_en(en_v),
    .m_valid(m_valid), .m_ready(m_ready), .m_dest_ip(m_dest_ip),
    .m_is_broadcast(m_is_broadcast), .m_is_multicast(m_is_multicast),
    .m_is_subnet_broadcast(m_is_subnet_broadcast), .m_is_local(m_is_local),
    .m_subnet_index(m_subnet_index),
    .stat_clear(stat_clear), .stat_bcast_cnt(stat_bcast_cnt),
    .stat_local_cnt(stat_local_cnt), .stat_remote_cnt(stat_remote_cnt)
  );

  typedef struct packed {
    logic [31:0] dest;
    logic        bc, mc, sbc, loc;
    logic [1:0]  idx;
  } res_t;
  typedef struct { res_t r; int cyc; } ent_t;
  typedef struct { logic [31:0] dest; res_t exp; } vec_t;

  ent_t q[$];
  int   vectors = 0, errs = 0, cyc = 0, acc_cnt = 0;
  bit   tbl_mode = 0, lat_chk = 0, hold = 0, rand_rdy = 0, rdy_fix = 0;
  res_t tbl_cur = '0, snap, mon_o;
  ent_t ent;

  function automatic res_t mk_res(logic [31:0] d, logic bc, logic mc, logic sbc, logic loc, logic [1:0] idx);
    return {d, bc, mc, sbc, loc, idx};
  endfunction

  // Address-level reference: the lowest-numbered enabled subnet containing the address wins.
  function automatic res_t model(logic [31:0] d);
    res_t r;
    r = mk_res(d, d == 32'hFFFF_FFFF, d[31:28] == 4'hE, 1'b0, 1'b0, 2'd0);
    for (int i = NS - 1; i >= 0; i--) begin
      if (en_v[i] && ((d & mk[i]) == (gw[i] & mk[i]))) begin
        r.loc = 1'b1;
        r.idx = 2'(i);
        r.sbc = ((d | mk[i]) == 32'hFFFF_FFFF) && (mk[i] != 32'hFFFF_FFFF);
      end
    end
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    m_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  always @(negedge clk) begin
    cyc++;
    mon_o = {m_dest_ip, m_is_broadcast, m_is_multicast, m_is_subnet_broadcast, m_is_local, m_subnet_index};
    if (rst) begin
      if (hold && m_valid) check("hold_stable", 64'(mon_o), 64'(snap));
      hold = m_valid && !m_ready;
      snap = mon_o;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL spurious_out: got dest %0h, expected no output", m_dest_ip);
        end else begin
          ent = q.pop_front();
          check("out", 64'(mon_o), 64'(ent.r));
          if (lat_chk) check("latency", 64'(cyc - ent.cyc), 64'd2);
        end
      end
      if (s_valid && s_ready) begin
        acc_cnt++;
        q.push_back('{tbl_mode ? tbl_cur : model(s_dest_ip), cyc});
      end
    end else begin
      hold = 0;
    end
  end

  task automatic send(input logic [31:0] d, input res_t e);
    int t;
    s_valid   = 1'b1;
    s_dest_ip = d;
    tbl_cur   = e;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!s_ready) begin
      vectors++;
      errs++;
      $display("FAIL send_timeout: got s_ready 0, expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      t++;
      @(posedge clk); #1;
    end
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic set_subnet(int i, logic [31:0] g, logic [31:0] m);
    gw[i] = g;
    mk[i] = m;
  endtask

  vec_t tbl[10];
  logic [31:0] d;
  int plen, j, a0;

  initial begin
    for (int i = 0; i < NS; i++) set_subnet(i, '0, '0);
    tbl[0] = '{32'hC0A8_01FF, mk_res(32'hC0A8_01FF, 0, 0, 1, 1, 0)};
    tbl[1] = '{32'hFFFF_FFFF, mk_res(32'hFFFF_FFFF, 1, 0, 0, 0, 0)};
    tbl[2] = '{32'hE000_0001, mk_res(32'hE000_0001, 0, 1, 0, 0, 0)};
    tbl[3] = '{32'h0A00_0005, mk_res(32'h0A00_0005, 0, 0, 0, 1, 1)};
    tbl[4] = '{32'h0A01_0203, mk_res(32'h0A01_0203, 0, 0, 0, 1, 1)};
    tbl[5] = '{32'h0AFF_FFFF, mk_res(32'h0AFF_FFFF, 0, 0, 1, 1, 1)};
    tbl[6] = '{32'hAC10_0509, mk_res(32'hAC10_0509, 0, 0, 0, 1, 2)};
    tbl[7] = '{32'hAC10_050A, mk_res(32'hAC10_050A, 0, 0, 0, 0, 0)};
    tbl[8] = '{32'h0A01_FFFF, mk_res(32'h0A01_FFFF, 0, 0, 0, 1, 1)};
    tbl[9] = '{32'hEFFF_FFFF, mk_res(32'hEFFF_FFFF, 0, 1, 0, 0, 0)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {m_valid, m_dest_ip, m_is_broadcast, m_is_multicast, m_is_subnet_broadcast, m_is_local, m_subnet_index}, '0);
    check("reset_counters", {stat_bcast_cnt, stat_local_cnt, stat_remote_cnt}, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_reset", 64'(s_ready), 64'd1);

    // Directed table, back-to-back at full throughput
    set_subnet(0, 32'hC0A8_0101, 32'hFFFF_FF00);
    set_subnet(1, 32'h0A00_0000, 32'hFF00_0000);
    set_subnet(2, 32'hAC10_0509, 32'hFFFF_FFFF);
    set_subnet(3, 32'h0A01_0000, 32'hFFFF_0000);
    en_v = 4'hF;
    rdy_fix = 1;
    @(posedge clk); #1;
    tbl_mode = 1;
    lat_chk  = 1;
    for (int i = 0; i < 10; i++) send(tbl[i].dest, tbl[i].exp);
    drain();
    tbl_mode = 0;

    // Three classes back-to-back with only subnet 0 enabled
    en_v = 4'b0001;
    send(32'hFFFF_FFFF, '0);
    send(32'hE000_0001, '0);
    send(32'h0A00_0005, '0);
    drain();
    lat_chk = 0;

    // Backpressure with a config change while both stages hold data
    en_v = 4'b0011;
    rdy_fix = 0;
    @(posedge clk); #1;
    a0 = acc_cnt;
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_dest_ip = 32'h0A00_0100 + 32'(k);
      if (k == 2) en_v = 4'b0001;
      @(posedge clk); #1;
    end
    check("stall_accepts", 64'(acc_cnt - a0), 64'd2);
    check("stall_s_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    rdy_fix = 1;
    send(32'h0A00_0200, '0);
    send(32'hC0A8_0107, '0);
    drain();
    check("stall_total_accepts", 64'(acc_cnt - a0), 64'd4);

    // Reset with both stages full
    rdy_fix = 0;
    @(posedge clk); #1;
    send(32'hC0A8_0110, '0);
    send(32'hC0A8_0111, '0);
    #2;
    check("full_before_reset", 64'(m_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("mvalid_async_reset", {m_valid, m_dest_ip}, '0);
    q.delete();
    rdy_fix = 1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_output_after_reset", 64'(m_valid), 64'd0);
    end
    check("counters_after_reset", {stat_bcast_cnt, stat_local_cnt, stat_remote_cnt}, '0);

    // Statistics
    @(posedge clk); #1;
    en_v = 4'b0001;
    for (int k = 1; k <= 20; k++) send(32'hC0A8_0100 + 32'(k), '0);
    drain();
`ifdef IP_CLASSIFIER_STATS_EN
    check("local_saturate", 64'(stat_local_cnt), 64'd15);
    check("bcast_zero", 64'(stat_bcast_cnt), 64'd0);
`else
    check("local_tied_zero", 64'(stat_local_cnt), 64'd0);
`endif
    s_valid = 1'b1;
    s_dest_ip = 32'hC0A8_0120;
    @(posedge clk); #1;
    s_valid = 1'b0;
    j = 0;
    @(negedge clk);
    while (!m_valid && j < 20) begin
      j++;
      @(negedge clk);
    end
    check("clear_setup_mvalid", 64'(m_valid), 64'd1);
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    check("clear_priority", 64'(stat_local_cnt), 64'd0);
    send(32'h0808_0808, '0);
    send(32'hC0A8_01FF, '0);
    send(32'hFFFF_FFFF, '0);
    drain();
`ifdef IP_CLASSIFIER_STATS_EN
    check("remote_cnt", 64'(stat_remote_cnt), 64'd1);
    check("bcast_cnt", 64'(stat_bcast_cnt), 64'd2);
    check("local_cnt", 64'(stat_local_cnt), 64'd1);
`else
    check("stats_tied_zero", {stat_bcast_cnt, stat_local_cnt, stat_remote_cnt}, '0);
`endif

    // Random traffic: boundary configs first, then random prefixes
    rand_rdy = 1;
    for (int it = 0; it < 320; it++) begin
      if (it % 40 == 0) begin
        case (it / 40)
          0: en_v = 4'b0000;
          1: begin en_v = 4'b0100; mk[2] = 32'h0; gw[2] = $urandom; end
          2: begin
            en_v = 4'hF;
            for (int i = 0; i < NS; i++) set_subnet(i, $urandom, 32'hFFFF_FFFF);
          end
          default: begin
            en_v = 4'($urandom);
            for (int i = 0; i < NS; i++) begin
              plen = $urandom_range(0, 32);
              set_subnet(i, $urandom, (plen == 0) ? 32'h0 : (32'hFFFF_FFFF << (32 - plen)));
            end
          end
        endcase
      end
      j = $urandom_range(0, NS - 1);
      case ($urandom_range(0, 9))
        0:       d = 32'hFFFF_FFFF;
        1:       d = {4'hE, 28'($urandom)};
        2, 3, 4: d = gw[j] ^ ($urandom & ~mk[j]);
        5, 6:    d = gw[j] | ~mk[j];
        default: d = $urandom;
      endcase
      send(d, '0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 0;
    rdy_fix  = 1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
